// File: rtl/tdc_fifo_writer.sv
// Writes one 5-byte frame (seq + 32-bit timestamp) into a byte FIFO per wr_en request.
// Frames stalled by fifo_full for FULL_TIMEOUT cycles are dropped and counted.
module tdc_fifo_writer #(
    parameter logic [15:0] FULL_TIMEOUT = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       fifo_full,
    output logic       fifo_wr,
    output logic [7:0] fifo_din,
    output logic       f_FIFO_writing_done,
    output logic       frame_dropped,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE, WAIT_LOW} state_t;

    state_t      state;
    logic [31:0] ts_cnt;
    logic [31:0] ts_cap;
    logic [7:0]  seq;
    logic [2:0]  idx;
    logic [15:0] tmo;
    logic        abort;
    logic [7:0]  cur_byte;

    always_comb begin
        cur_byte = 8'd0;
        case (idx)
            3'd0:    cur_byte = seq;
            3'd1:    cur_byte = ts_cap[31:24];
            3'd2:    cur_byte = ts_cap[23:16];
            3'd3:    cur_byte = ts_cap[15:8];
            3'd4:    cur_byte = ts_cap[7:0];
            default: cur_byte = 8'd0;
        endcase
    end

    // Outputs are masked by rst so nothing leaks out during the reset cycle.
    assign fifo_wr             = !rst && (state == WRITE) && !fifo_full;
    assign fifo_din            = (!rst && (state == WRITE)) ? cur_byte : 8'd0;
    assign f_FIFO_writing_done = !rst && (state == DONE);
    assign frame_dropped       = !rst && (state == DONE) && abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ts_cnt   <= 32'd0;
            ts_cap   <= 32'd0;
            seq      <= 8'd0;
            idx      <= 3'd0;
            tmo      <= 16'd0;
            abort    <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        ts_cap <= ts_cnt;
                        idx    <= 3'd0;
                        tmo    <= 16'd0;
                        abort  <= 1'b0;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (!fifo_full) begin
                        tmo <= 16'd0;
                        idx <= idx + 3'd1;
                        if (idx == 3'd4) state <= DONE;
                    end else begin
                        tmo <= tmo + 16'd1;
                        // 17-bit compare so a stall count at the 16-bit limit cannot wrap past the limit
                        if (({1'b0, tmo} + 17'd1) >= {1'b0, FULL_TIMEOUT}) begin
                            abort <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    seq <= seq + 8'd1;
                    if (abort && drop_cnt != 8'd255) drop_cnt <= drop_cnt + 8'd1;
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!wr_en) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
